// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch (F) and the
// data-memory (M) requesters. One transaction at a time is sequenced through
// IDLE -> REQ -> WAIT -> RESP. The WAIT state has a timeout that aborts the
// transaction and returns zero data.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   if_req/if_addr      fetch read request (held until if_gnt), 4-byte aligned
//   if_gnt/if_rvalid    one-cycle pulses: accepted / if_rdata valid
//   if_rdata            32-bit instruction word (selected half of the doubleword)
//   dm_req/dm_we        data request (held until dm_gnt), 1 = write
//   dm_addr/dm_wdata    doubleword address and write data
//   dm_be               write byte enables
//   dm_gnt/dm_rvalid    one-cycle pulses: accepted / read data or write ack
//   dm_rdata            64-bit read data (0 for writes)
//   mem_req..mem_be     request to memory, driven only in REQ
//   mem_ready           memory accepts the request this cycle
//   mem_rvalid/rdata    memory response, one cycle
//   stall_f/stall_m     requester pending and not yet answered
//   err                 one-cycle pulse on timeout abort
//
// Optional feature macro: ARB_FAIRNESS_EN
//   When defined, a starve counter forces a fetch win after MAX_STARVE
//   consecutive data wins that happened while fetch was waiting.
//   When undefined, data always has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  input  logic [7:0]  dm_be,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [63:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [7:0] TimeoutCnt  = 8'(TIMEOUT);
  localparam logic [3:0] StarveLimit = 4'(MAX_STARVE);

  state_e      state_q, state_d;
  logic        ownerData_q, ownerData_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fetchForced;
  logic        unusedBits;

  // The low address bits never reach memory; addr_q[2] alone picks the
  // instruction half. The starve limit is only consumed by the fairness build.
  assign unusedBits = ^{addr_q[1:0], StarveLimit};

`ifdef ARB_FAIRNESS_EN
  logic [3:0] starve_q, starve_d;

  // Starve counter: counts data wins taken while fetch was also waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  assign fetchForced = if_req && (starve_q == StarveLimit);
`else
  assign fetchForced = 1'b0;
`endif

  // Transaction state: the FSM plus everything latched at arbitration time,
  // so the requesters are free to change their inputs after the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ownerData_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ownerData_q <= ownerData_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and output decode. Every output defaults to 0 so that nothing
  // belonging to the idle requester or to memory leaks out in other states.
  always_comb begin
    state_d     = state_q;
    ownerData_d = ownerData_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
`ifdef ARB_FAIRNESS_EN
    starve_d    = starve_q;
`endif
    if_gnt      = 1'b0;
    if_rvalid   = 1'b0;
    if_rdata    = '0;
    dm_gnt      = 1'b0;
    dm_rvalid   = 1'b0;
    dm_rdata    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;
    err         = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_req && !fetchForced) begin
          ownerData_d = 1'b1;
          we_d        = dm_we;
          addr_d      = dm_addr;
          wdata_d     = dm_wdata;
          be_d        = dm_we ? dm_be : 8'hFF;
          state_d     = REQ;
`ifdef ARB_FAIRNESS_EN
          if (if_req) starve_d = starve_q + 4'd1;
`endif
        end else if (if_req) begin
          ownerData_d = 1'b0;
          we_d        = 1'b0;
          addr_d      = if_addr;
          wdata_d     = '0;
          be_d        = 8'hFF;
          state_d     = REQ;
`ifdef ARB_FAIRNESS_EN
          starve_d    = '0;
`endif
        end
      end

      REQ: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[63:3], 3'b000};
        mem_wdata = wdata_q;
        mem_be    = be_q;
        if (mem_ready) begin
          if (ownerData_q) dm_gnt = 1'b1;
          else             if_gnt = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      // A response on the very cycle the limit is hit still wins over abort.
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else if (cnt_q == TimeoutCnt) begin
          err     = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RESP: begin
        if (ownerData_q) begin
          dm_rvalid = 1'b1;
          dm_rdata  = we_q ? 64'd0 : rdata_q;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Stalls drop only in the cycle the owner's answer is presented.
  assign stall_f = if_req && !(state_q == RESP && !ownerData_q);
  assign stall_m = dm_req && !(state_q == RESP && ownerData_q);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch requester and the data-memory requester of the 5-stage core. It accepts one transaction at a time and sequences it through a request/accept/response handshake with the backing memory. It returns read data, or a write acknowledge, to the winning requester. It also produces per-requester stall signals that the hazard logic uses to freeze the F or M stage.

Parameters:
MAX_STARVE, 4, consecutive data wins allowed while fetch waits (fairness feature only); range 1-15
TIMEOUT, 255, max cycles in WAIT before abort; 8-bit counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
if_req  input  1  fetch read request; held until if_gnt
if_addr  input  64  fetch byte address, 4-byte aligned
if_gnt  output  1  one-cycle pulse: fetch request accepted by memory
if_rvalid  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  32  instruction word
dm_req  input  1  data request; held until dm_gnt
dm_we  input  1  1=write, 0=read
dm_addr  input  64  data byte address, 8-byte aligned doubleword
dm_wdata  input  64  write data
dm_be  input  8  byte enables for writes
dm_gnt  output  1  one-cycle pulse: data request accepted
dm_rvalid  output  1  one-cycle pulse: read data or write ack
dm_rdata  output  64  read data (0 for writes)
mem_req  output  1  request to memory, held until mem_ready
mem_we  output  1  write strobe
mem_addr  output  64  address, doubleword aligned (addr[2:0]=0)
mem_wdata  output  64  write data
mem_be  output  8  byte enables (8'hFF for reads)
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  response / write ack, one cycle
mem_rdata  input  64  memory read data
stall_f  output  1  fetch pending and not yet responded
stall_m  output  1  data pending and not yet responded
err  output  1  one-cycle pulse on timeout abort

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- IDLE: if dm_req, select DATA; else if if_req, select FETCH. Data has priority on simultaneous requests. On selection, latch addr/we/wdata/be and the owner, then go to REQ. mem_rvalid in IDLE is ignored.
- REQ: mem_req=1 driven from the latched values.
  - On mem_req&&mem_ready: pulse the owner's gnt that cycle, go to WAIT, clear the timeout counter.
  - Requester inputs are not re-sampled in REQ.
- WAIT: counter increments each cycle.
  - On mem_rvalid: capture mem_rdata and go to RESP.
  - If the counter reaches TIMEOUT without mem_rvalid: pulse err, go to RESP with captured data = 0.
- RESP: pulse the owner's rvalid with registered data, then go to IDLE.
  - FETCH: if_rdata = addr[2] ? rdata[63:32] : rdata[31:0].
  - Data write: dm_rdata = 0.
- Minimum latency, with ready and rvalid both at first opportunity:
  - Request sampled in cycle 0.
  - mem_req and gnt in cycle 1.
  - mem_rvalid in cycle 2.
  - rvalid to requester in cycle 3.
  - Next arbitration in cycle 4.
- stall_f = if_req && !(owner==FETCH && state==RESP). stall_m follows the same rule for DATA. Both are combinational.
- Outputs not owned by the current transaction are 0. mem_* are 0 outside REQ.
- Reset (asserted low, asynchronous, any time): state=IDLE, counters=0, all outputs 0. A transaction in flight is abandoned. A mem_rvalid arriving after reset release is ignored because the state is IDLE.

Optional Feature:
ARB_FAIRNESS_EN
- Defined: a 4-bit starve counter increments each time DATA wins in IDLE while if_req=1. It clears when FETCH wins.
  - When the counter equals MAX_STARVE, FETCH wins the next IDLE arbitration even if dm_req=1.
- Undefined: fixed data priority; no starve counter.

Test Plan:
- Single fetch, if_addr=0x1004, mem_ready=1, mem_rvalid one cycle after accept, mem_rdata=0xAAAABBBB_CCCCDDDD -> mem_addr=0x1000, if_gnt at cycle 1, if_rvalid at cycle 3 with if_rdata=0xAAAABBBB.
- Simultaneous if_req and dm_req (read, addr 0x2000) -> DATA served first; dm_rvalid at cycle 3; fetch mem_req at cycle 5; stall_f high throughout.
- Data write, dm_be=0x0F, mem_ready low 3 cycles -> mem_req held 4 cycles with stable addr/wdata/be; dm_gnt exactly once; dm_rvalid with dm_rdata=0.
- No mem_rvalid after accept, TIMEOUT=255 -> err pulse 255 cycles after entering WAIT; owner rvalid with data 0; next request is accepted normally.
- Reset asserted in WAIT, then a stray mem_rvalid after release -> all outputs 0 immediately; no rvalid or err produced; next if_req completes normally.
- With ARB_FAIRNESS_EN, MAX_STARVE=4, dm_req and if_req both held -> order DATA×4, FETCH, DATA×4, ... Without the macro: DATA only while dm_req=1.
